uart_frame_scheduler: RTL
=========================

// Module: uart_frame_scheduler
// PURPOSE
//  Shares the frame-based UART core (uart_top) between NREQ on-chip requesters.
//  TX side: round-robin arbitration, frame latch, tx_trigger pulse, then a holdoff long enough for the frame to drain.
//  RX side: detects each newly received frame and routes it to one requester, selected by the frame's first byte.
//  Sits between uart_top and the control logic in top, replacing ad-hoc tx_trigger/tx_in driving.
// PARAMETERS
//  NREQ            4        number of requesters, 2..8
//  DBITS           8        bits per UART byte
//  FRAME_BYTES     18       bytes per frame; must equal the FIFO_IN_SIZE/FIFO_OUT_SIZE of uart_top
//  HOLDOFF_CYCLES  1800     clk cycles after a trigger before the next grant; >=2
//  RX_ID_BASE      8'h41    byte0 value ("A") that addresses requester 0
// PORTS
//  clk         in   1                       system clock (single domain)
//  reset       in   1                       synchronous, active-high
//  req         in   NREQ                    per-requester send request; level, held until gnt
//  req_frame   in   NREQ*FRAME_BITS         per-requester frame; slot i is bits [i*FRAME_BITS +: FRAME_BITS]
//  gnt         out  NREQ                    one-hot, one-cycle pulse: frame of slot i latched
//  busy        out  1                       high in every state except IDLE
//  tx_trigger  out  1                       to uart_top.tx_trigger; one-cycle pulse
//  tx_in       out  FRAME_BITS              to uart_top.tx_in; registered, stable from grant to end of HOLD
//  rx_empty    in   1                       from uart_top.rx_empty
//  rx_out      in   FRAME_BITS              from uart_top.rx_out; byte0 = bits [DBITS-1:0]
//  rx_valid    out  NREQ                    one-hot, one-cycle pulse: rx_frame addressed to requester i
//  rx_frame    out  FRAME_BITS              registered copy of rx_out; valid with rx_valid/rx_drop
//  rx_drop     out  1                       one-cycle pulse: byte0 out of range, frame discarded
//  FRAME_BITS = FRAME_BYTES*DBITS (derived, 144 at default)
// BEHAVIOUR
//  Reset (sync, any state, overrides all):
//   - state=IDLE; gnt, tx_trigger, busy, rx_valid, rx_drop = 0; tx_in, rx_frame = 0
//   - rr_last=NREQ-1, so requester 0 wins first; holdoff counter=0; rx_empty_q=1
//   - a frame mid-HOLD is abandoned; the UART is not reset by this block
//  TX FSM:
//   - IDLE: if |req, pick the first set bit scanning from rr_last+1 with wrap. Registered: gnt[w]=1,
//     tx_in<=slot w, rr_last<=w, state->FIRE. No req: stay in IDLE.
//   - FIRE (1 cycle): tx_trigger=1; counter<=HOLDOFF_CYCLES-1; ->HOLD.
//   - HOLD: counter decrements each cycle; at 0 ->IDLE. req is ignored throughout.
//   - Latency: req high in IDLE at edge N -> gnt high in cycle N+1 -> tx_trigger in cycle N+2.
//   - Trigger-to-trigger spacing >= HOLDOFF_CYCLES+2 cycles.
//   - A requester still holding req after its gnt is served again in a later round, not sooner.
//   - Simultaneous requests: exactly one gnt bit. Under continuous contention, service is strict
//     rotation with no starvation.
//   - A req deasserted before its grant is simply not served; no error is raised.
//  RX path (independent of TX, runs in any TX state):
//   - rx_empty_q <= rx_empty every cycle. new_frame = rx_empty_q & ~rx_empty (1->0 edge).
//   - On new_frame: rx_frame<=rx_out; id=byte0-RX_ID_BASE, computed unsigned in DBITS bits.
//     id<NREQ: rx_valid[id] pulses next cycle. Otherwise rx_drop pulses next cycle.
//   - Latency: edge cycle -> pulse one cycle later. rx_frame holds its value until the next new_frame.
//   - A frame arriving while rx_empty stays 0 (FIFO refilled with no empty gap) is not detected.
//     This is a known limitation of uart_top's interface; no pop handshake exists.
// STRUCTURE
//  - Shared header uart_ctrl_defs.vh: TX state encodings (IDLE/FIRE/HOLD, 2 bits) and the FRAME_BITS macro.
//    uart_top users include the same header.
//  - Sub-module rr_arbiter #(N): combinational inputs req and last, output one-hot win plus its index.
//    Holds no state.
//  - rr_last and the FSM register stay in uart_frame_scheduler.
// TESTING (HOLDOFF_CYCLES=20 in the bench)
//  - Single request: req=4'b0010, slot1="HELLO" -> gnt=4'b0010 one cycle; next cycle tx_trigger=1;
//    tx_in="HELLO" held for 22 cycles; busy falls after 22 cycles.
//  - Contention: req=4'b1111 held -> gnt order 0,1,2,3,0. Trigger spacing exactly 22 cycles.
//  - Late request: assert req[2] during HOLD -> no gnt until HOLD ends; then gnt=4'b0100 on the first IDLE edge.
//  - RX routing: rx_empty 1->0 with byte0="C" -> rx_valid=4'b0100 one cycle later, rx_frame=rx_out.
//    byte0="Z" -> rx_drop=1 and rx_valid=0.
//  - Reset mid-HOLD: pulse reset during HOLD -> next cycle state IDLE and all outputs 0.
//    req=4'b1001 -> gnt=4'b0001.
//  - Concurrent: RX edge in the FIRE cycle -> rx_valid and tx_trigger timings both unaffected.

Source files
------------

// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler: TX state encoding and default geometry.
package uart_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } tx_state_e;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_DBITS       = 8;
  localparam int DEF_FRAME_BYTES = 18;
  localparam int DEF_HOLDOFF     = 1800;

  function automatic int frame_bits(input int bytes, input int dbits);
    return bytes * dbits;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Stateless round-robin pick: first set request scanning upward from last+1, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         win_o,
  output logic [$clog2(N)-1:0] win_idx_o
);

  logic                 found;
  logic [$clog2(N)-1:0] sel;
  int                   idx;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      sel = $clog2(N)'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        win_o[sel] = 1'b1;
        win_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one frame-based UART between NREQ requesters: round-robin TX with holdoff,
// and RX routing of each newly arrived frame by its first byte.
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int               NREQ           = DEF_NREQ,
  parameter int               DBITS          = DEF_DBITS,
  parameter int               FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int               HOLDOFF_CYCLES = DEF_HOLDOFF,
  parameter logic [DBITS-1:0] RX_ID_BASE     = 'h41
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ*FRAME_BYTES*DBITS-1:0]   req_frame,
  output logic [NREQ-1:0]                     gnt,
  output logic                                busy,
  output logic                                tx_trigger,
  output logic [FRAME_BYTES*DBITS-1:0]        tx_in,
  input  logic                                rx_empty,
  input  logic [FRAME_BYTES*DBITS-1:0]        rx_out,
  output logic [NREQ-1:0]                     rx_valid,
  output logic [FRAME_BYTES*DBITS-1:0]        rx_frame,
  output logic                                rx_drop,
  output logic [1:0]                          dbg_state
);

  localparam int FB = frame_bits(FRAME_BYTES, DBITS);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLDOFF_CYCLES);

  tx_state_e       state_q;
  logic [NREQ-1:0] gnt_q;
  logic            trig_q;
  logic            busy_q;
  logic [FB-1:0]   tx_in_q;
  logic [IW-1:0]   rr_last_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic [FB-1:0]   win_frame;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i     (req),
    .last_i    (rr_last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_comb begin
    win_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_frame = req_frame[i*FB +: FB];
    end
  end

  // Requests are only sampled in IDLE, so anything raised during FIRE/HOLD waits its turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_in_q   <= '0;
      rr_last_q <= IW'(NREQ - 1);
      cnt_q     <= '0;
    end else begin
      gnt_q  <= '0;
      trig_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q     <= win;
            tx_in_q   <= win_frame;
            rr_last_q <= win_idx;
            busy_q    <= 1'b1;
            state_q   <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          trig_q  <= 1'b1;
          cnt_q   <= CW'(HOLDOFF_CYCLES - 1);
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  logic             rx_empty_q;
  logic [NREQ-1:0]  rx_valid_q;
  logic             rx_drop_q;
  logic [FB-1:0]    rx_frame_q;
  logic             new_frame;
  logic [DBITS-1:0] rx_id;
  logic [NREQ-1:0]  rx_valid_d;
  logic             rx_drop_d;

  // Only a 1->0 edge on rx_empty marks a fresh frame; back-to-back refills are invisible.
  assign new_frame = rx_empty_q & ~rx_empty;
  assign rx_id     = rx_out[DBITS-1:0] - RX_ID_BASE;

  always_comb begin
    rx_valid_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      rx_valid_d[i] = new_frame && (rx_id == DBITS'(i));
    end
    rx_drop_d = new_frame && !(rx_id < DBITS'(NREQ));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_empty_q <= 1'b1;
      rx_valid_q <= '0;
      rx_drop_q  <= 1'b0;
      rx_frame_q <= '0;
    end else begin
      rx_empty_q <= rx_empty;
      rx_valid_q <= rx_valid_d;
      rx_drop_q  <= rx_drop_d;
      if (new_frame) rx_frame_q <= rx_out;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign tx_trigger = trig_q;
  assign tx_in      = tx_in_q;
  assign rx_valid   = rx_valid_q;
  assign rx_drop    = rx_drop_q;
  assign rx_frame   = rx_frame_q;
  assign dbg_state  = state_q;

endmodule
